// File: rtl/trex_pkg.sv
// Shared constants, state encodings and BCD helper for the T-Rex game slice.
package trex_pkg;

    localparam int POS_W = 11;
    localparam int SIZE_W = 10;
    localparam int BCD_W = 16;

    localparam int SCORE_DIV = 6;
    localparam logic [3:0] SPEED_INIT = 4'd3;
    localparam logic [3:0] SPEED_MAX = 4'd12;
    localparam int DEAD_HOLD = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Ripple a +1 through four BCD digits; 9999 wraps here, callers saturate.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic carry;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Frame-level bus between the sprite/physics stage and game_ctrl.
// hiscore_bcd exists only when GAME_CTRL_HISCORE_EN is defined.
interface game_ctrl_if;
    import trex_pkg::*;

    logic              start;
    logic [POS_W-1:0]  Dino_X;
    logic [POS_W-1:0]  Dino_Y;
    logic [SIZE_W-1:0] DinoWidth;
    logic [SIZE_W-1:0] DinoHeight;
    logic [POS_W-1:0]  ObsX;
    logic [POS_W-1:0]  ObsY;
    logic [SIZE_W-1:0] ObsW;
    logic [SIZE_W-1:0] ObsH;
    logic              ObsValid;
    state_t            state;
    logic              running;
    logic              isDead;
    logic [BCD_W-1:0]  score_bcd;
    logic [3:0]        speed;
`ifdef GAME_CTRL_HISCORE_EN
    logic [BCD_W-1:0]  hiscore_bcd;
`endif

`ifdef GAME_CTRL_HISCORE_EN
    modport master (
        output start, Dino_X, Dino_Y, DinoWidth, DinoHeight,
               ObsX, ObsY, ObsW, ObsH, ObsValid,
        input  state, running, isDead, score_bcd, speed, hiscore_bcd
    );
    modport slave (
        input  start, Dino_X, Dino_Y, DinoWidth, DinoHeight,
               ObsX, ObsY, ObsW, ObsH, ObsValid,
        output state, running, isDead, score_bcd, speed, hiscore_bcd
    );
`else
    modport master (
        output start, Dino_X, Dino_Y, DinoWidth, DinoHeight,
               ObsX, ObsY, ObsW, ObsH, ObsValid,
        input  state, running, isDead, score_bcd, speed
    );
    modport slave (
        input  start, Dino_X, Dino_Y, DinoWidth, DinoHeight,
               ObsX, ObsY, ObsW, ObsH, ObsValid,
        output state, running, isDead, score_bcd, speed
    );
`endif

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter that saturates at 9999.
module bcd_counter4
    import trex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             hund_roll
);

    logic [BCD_W-1:0] value_q;
    logic             step;

    assign step      = inc & (value_q != 16'h9999);
    assign hund_roll = step & (value_q[7:0] == 8'h99);
    assign value     = value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (step) begin
            value_q <= bcd_inc(value_q);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Frame-rate game supervisor: collision detect, IDLE/RUN/DEAD FSM, score and speed.
// Define GAME_CTRL_HISCORE_EN to add the hiscore_bcd register and port.
module game_ctrl
    import trex_pkg::*;
#(
    parameter int ScoreDiv = SCORE_DIV
) (
    input  logic       FrameClk,
    input  logic       rst,
    game_ctrl_if.slave io
);

    localparam int FW = $clog2(ScoreDiv + 1);
    localparam int HW = $clog2(DEAD_HOLD);

    state_t           state_q;
    logic             running_q;
    logic             isDead_q;
    logic             start_q;
    logic [FW-1:0]    frame_q;
    logic [HW-1:0]    hold_q;
    logic [3:0]       speed_q;
    logic [BCD_W-1:0] score;
    logic             hundRoll;
    logic             rise;
    logic             hit;
    logic             tick;
    logic             holdDone;
    logic             restart;
    logic             scoreInc;
    logic [11:0]      obsRight, obsBottom, dinoRight, dinoBottom;
`ifdef GAME_CTRL_HISCORE_EN
    logic [BCD_W-1:0] hiscore_q;
`endif

    // Strict inequalities so boxes sharing only an edge do not collide.
    assign obsRight   = 12'(io.ObsX) + 12'(io.ObsW);
    assign obsBottom  = 12'(io.ObsY) + 12'(io.ObsH);
    assign dinoRight  = 12'(io.Dino_X) + 12'(io.DinoWidth);
    assign dinoBottom = 12'(io.Dino_Y) + 12'(io.DinoHeight);
    assign hit = io.ObsValid
               & (12'(io.Dino_X) < obsRight)  & (12'(io.ObsX) < dinoRight)
               & (12'(io.Dino_Y) < obsBottom) & (12'(io.ObsY) < dinoBottom);

    assign rise     = io.start & ~start_q;
    assign tick     = (frame_q == FW'(ScoreDiv - 1));
    assign holdDone = (hold_q == HW'(DEAD_HOLD - 1));
    assign restart  = rise & ((state_q == ST_IDLE) | ((state_q == ST_DEAD) & holdDone));
    assign scoreInc = (state_q == ST_RUN) & ~hit & tick;

    bcd_counter4 u_score (
        .clk       (FrameClk),
        .rst       (rst),
        .clr       (restart),
        .inc       (scoreInc),
        .value     (score),
        .hund_roll (hundRoll)
    );

    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            isDead_q  <= 1'b0;
            start_q   <= 1'b0;
            frame_q   <= '0;
            hold_q    <= '0;
            speed_q   <= SPEED_INIT;
`ifdef GAME_CTRL_HISCORE_EN
            hiscore_q <= '0;
`endif
        end else begin
            start_q <= io.start;
            case (state_q)
                ST_IDLE, ST_DEAD: begin
                    if (restart) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                        isDead_q  <= 1'b0;
                        frame_q   <= '0;
                        speed_q   <= SPEED_INIT;
                    end else if ((state_q == ST_DEAD) && !holdDone) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        state_q   <= ST_DEAD;
                        running_q <= 1'b0;
                        isDead_q  <= 1'b1;
                        hold_q    <= '0;
`ifdef GAME_CTRL_HISCORE_EN
                        if (score > hiscore_q) begin
                            hiscore_q <= score;
                        end
`endif
                    end else begin
                        frame_q <= tick ? '0 : frame_q + 1'b1;
                        if (hundRoll && (speed_q < SPEED_MAX)) begin
                            speed_q <= speed_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    isDead_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io.state     = state_q;
    assign io.running   = running_q;
    assign io.isDead    = isDead_q;
    assign io.score_bcd = score;
    assign io.speed     = speed_q;
`ifdef GAME_CTRL_HISCORE_EN
    assign io.hiscore_bcd = hiscore_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl; a second fast-scoring instance covers saturation.
// Hi-score checks are active when GAME_CTRL_HISCORE_EN is defined.
module tb_game_ctrl;
    import trex_pkg::*;

    logic FrameClk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    game_ctrl_if gcIf ();
    game_ctrl_if fastIf ();

    game_ctrl dut (
        .FrameClk (FrameClk),
        .rst      (rst),
        .io       (gcIf)
    );

    // Scores one point per running frame so the 9999 ceiling is reachable quickly.
    game_ctrl #(.ScoreDiv(1)) dutFast (
        .FrameClk (FrameClk),
        .rst      (rst),
        .io       (fastIf)
    );

    always #5 FrameClk = ~FrameClk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FrameClk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic startV, input logic [10:0] obsX, input logic valid);
        gcIf.start    = startV;
        gcIf.ObsX     = obsX;
        gcIf.ObsValid = valid;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        gcIf.Dino_X = 11'd50;  gcIf.Dino_Y = 11'd100;
        gcIf.DinoWidth = 10'd40; gcIf.DinoHeight = 10'd43;
        gcIf.ObsY = 11'd120; gcIf.ObsW = 10'd20; gcIf.ObsH = 10'd30;
        applyStimulus(1'b0, 11'd300, 1'b0);
        fastIf.start = 1'b0;
        fastIf.Dino_X = 11'd50;  fastIf.Dino_Y = 11'd100;
        fastIf.DinoWidth = 10'd40; fastIf.DinoHeight = 10'd43;
        fastIf.ObsX = 11'd89; fastIf.ObsY = 11'd120;
        fastIf.ObsW = 10'd20; fastIf.ObsH = 10'd30;
        fastIf.ObsValid = 1'b0;

        #1 rst = 1'b1;
        #1;
        checkOutput("rst_state", 16'(gcIf.state), 16'd0);
        checkOutput("rst_running", 16'(gcIf.running), 16'd0);
        checkOutput("rst_isDead", 16'(gcIf.isDead), 16'd0);
        checkOutput("rst_score", gcIf.score_bcd, 16'h0000);
        checkOutput("rst_speed", 16'(gcIf.speed), 16'd3);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("rst_hiscore", gcIf.hiscore_bcd, 16'h0000);
`endif
        @(negedge FrameClk);
        rst = 1'b0;

        $display("[TB] start and first score point");
        applyStimulus(1'b1, 11'd300, 1'b0);
        tick(1);
        checkOutput("start_running", 16'(gcIf.running), 16'd1);
        checkOutput("start_state", 16'(gcIf.state), 16'd1);
        tick(5);
        checkOutput("score_before_div", gcIf.score_bcd, 16'h0000);
        tick(1);
        checkOutput("score_first_point", gcIf.score_bcd, 16'h0001);

        $display("[TB] collision edge cases");
        applyStimulus(1'b1, 11'd90, 1'b1);
        tick(1);
        checkOutput("touch_edge_no_hit", 16'(gcIf.state), 16'd1);
        applyStimulus(1'b1, 11'd89, 1'b0);
        tick(1);
        checkOutput("obs_invalid_no_hit", 16'(gcIf.state), 16'd1);
        tick(3);
        checkOutput("score_before_tie", gcIf.score_bcd, 16'h0001);
        applyStimulus(1'b1, 11'd89, 1'b1);
        tick(1);
        checkOutput("tie_isDead", 16'(gcIf.isDead), 16'd1);
        checkOutput("tie_running", 16'(gcIf.running), 16'd0);
        checkOutput("tie_state", 16'(gcIf.state), 16'd2);
        checkOutput("tie_score_held", gcIf.score_bcd, 16'h0001);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("hiscore_first_death", gcIf.hiscore_bcd, 16'h0001);
`endif

        $display("[TB] restart lockout");
        applyStimulus(1'b0, 11'd89, 1'b0);
        tick(9);
        applyStimulus(1'b1, 11'd89, 1'b0);
        tick(1);
        checkOutput("lockout_frame10", 16'(gcIf.state), 16'd2);
        applyStimulus(1'b0, 11'd89, 1'b0);
        tick(18);
        applyStimulus(1'b1, 11'd89, 1'b0);
        tick(1);
        checkOutput("lockout_frame29", 16'(gcIf.state), 16'd2);
        applyStimulus(1'b0, 11'd89, 1'b0);
        tick(1);
        applyStimulus(1'b1, 11'd89, 1'b0);
        tick(1);
        checkOutput("restart_state", 16'(gcIf.state), 16'd1);
        checkOutput("restart_score", gcIf.score_bcd, 16'h0000);
        checkOutput("restart_speed", 16'(gcIf.speed), 16'd3);

        applyStimulus(1'b1, 11'd89, 1'b1);
        tick(1);
        checkOutput("second_death_state", 16'(gcIf.state), 16'd2);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("hiscore_kept", gcIf.hiscore_bcd, 16'h0001);
`endif

        $display("[TB] speed steps and saturation");
        fastIf.start = 1'b1;
        tick(1);
        checkOutput("fast_running", 16'(fastIf.running), 16'd1);
        tick(99);
        checkOutput("fast_score_0099", fastIf.score_bcd, 16'h0099);
        checkOutput("fast_speed_0099", 16'(fastIf.speed), 16'd3);
        tick(1);
        checkOutput("fast_score_0100", fastIf.score_bcd, 16'h0100);
        checkOutput("fast_speed_0100", 16'(fastIf.speed), 16'd4);
        tick(799);
        checkOutput("fast_speed_0899", 16'(fastIf.speed), 16'd11);
        tick(1);
        checkOutput("fast_score_0900", fastIf.score_bcd, 16'h0900);
        checkOutput("fast_speed_0900", 16'(fastIf.speed), 16'd12);
        tick(100);
        checkOutput("fast_speed_max_hold", 16'(fastIf.speed), 16'd12);
        tick(8999);
        checkOutput("fast_score_9999", fastIf.score_bcd, 16'h9999);
        tick(12);
        checkOutput("fast_score_sat", fastIf.score_bcd, 16'h9999);
        checkOutput("fast_speed_sat", 16'(fastIf.speed), 16'd12);

        $display("[TB] asynchronous reset mid-game");
        rst = 1'b1;
        #1;
        checkOutput("midrst_state", 16'(gcIf.state), 16'd0);
        checkOutput("midrst_isDead", 16'(gcIf.isDead), 16'd0);
        checkOutput("midrst_fast_score", fastIf.score_bcd, 16'h0000);
        checkOutput("midrst_fast_speed", 16'(fastIf.speed), 16'd3);
        checkOutput("midrst_fast_running", 16'(fastIf.running), 16'd0);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("midrst_hiscore", gcIf.hiscore_bcd, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-rate game supervisor that sits directly downstream of the T-Rex sprite/physics stage. Each frame it consumes the dino bounding box and the active obstacle bounding box, detects collision, and runs the IDLE/RUN/DEAD game state machine. It drives `isDead` back to the dino animation FSM, and drives score and scroll speed to the obstacle generator and score renderer.

## Interface
- `SCORE_DIV`, 6: frames per score point while running.
- `SPEED_INIT`, 4'd3: scroll speed after reset and after each restart, in px/frame.
- `SPEED_MAX`, 4'd12: speed saturation value.
- `DEAD_HOLD`, 30: frames after death during which `start` is ignored.

Ports:
- `rst`, in, 1: reset, asynchronous, active-high.
- `FrameClk`, in, 1: clock, one rising edge per video frame.
- `start`, in, 1: jump/start button level, already synchronised upstream.
- `Dino_X`, `Dino_Y`, in, 11 each: dino top-left corner, in pixels.
- `DinoWidth`, `DinoHeight`, in, 10 each: dino box size.
- `ObsX`, `ObsY`, in, 11 each: obstacle top-left corner.
- `ObsW`, `ObsH`, in, 10 each: obstacle box size.
- `ObsValid`, in, 1: an obstacle is on screen.
- `state`, out, 2: 0 = IDLE, 1 = RUN, 2 = DEAD (3 is unused).
- `running`, out, 1: `state` == RUN.
- `isDead`, out, 1: `state` == DEAD.
- `score_bcd`, out, 16: four BCD digits, with the thousands digit at [15:12].
- `speed`, out, 4: obstacle scroll speed.
- `hiscore_bcd`, out, 16: best score; present only when `HISCORE_EN` is defined.

## Operation
- **Start detect:** `start_q` registers `start` every frame. `rise` = `start & ~start_q`.
- **Collision (`hit`):** combinational, all sums 12-bit unsigned. `hit` is true when all of the following hold:
  - `ObsValid` is high.
  - `Dino_X < ObsX+ObsW` and `ObsX < Dino_X+DinoWidth`.
  - `Dino_Y < ObsY+ObsH` and `ObsY < Dino_Y+DinoHeight`.
  - Boxes that only touch along an edge do not collide.
- **FSM transitions:**
  - IDLE: `rise` → RUN. On entry to RUN, score is cleared, speed is set to `SPEED_INIT`, and the frame counter is cleared.
  - RUN: `hit` → DEAD. Otherwise the frame counter increments. When it reaches `SCORE_DIV-1`, it wraps to 0 and the score increments.
  - DEAD: the hold counter runs from 0 to `DEAD_HOLD-1`, then stops. `rise` after the hold has completed → RUN with a full restart. `rise` during the hold is ignored.
- **Score:** BCD increment with saturation. At 9999 the score stays at 9999.
- **Speed:** +1 on every increment where the tens and units digits roll to 00 (0099→0100, 0199→0200, and so on). Speed saturates at `SPEED_MAX`. Once the score is saturated, speed no longer changes.
- **Simultaneous events:** in RUN, when `hit` and a score tick occur on the same edge, `hit` wins and the score is not incremented.
- **DEAD state:** score and speed hold their values.

## Timing
- **Reset values (async, immediate):**
  - `state` = IDLE; `running` = 0; `isDead` = 0.
  - `score_bcd` = 0; `speed` = `SPEED_INIT`; `hiscore_bcd` = 0.
  - `start_q` = 0; all internal counters = 0.
- **Registered outputs:** every output is registered. An input condition sampled at edge N is visible after edge N.
- **Start latency:** `start` rising before edge N gives RUN after edge N. The first score point appears after edge N+`SCORE_DIV`.
- **Collision latency:** `hit` true at edge N gives `isDead` = 1 after edge N. The dino FSM sees it on its next animation clock.
- **Reset mid-game:** returns to IDLE immediately. `hiscore_bcd` is also cleared.
- **Held button:** a `start` held continuously produces only one `rise`. The player must release the button to restart.

## Configuration
- `GAME_CTRL_HISCORE_EN` **defined:**
  - Adds the `hiscore_bcd` port and register.
  - On each RUN→DEAD transition, if `score_bcd` > `hiscore_bcd` (compared as BCD, equivalent to an unsigned compare), then `hiscore_bcd` ← `score_bcd` on the same edge.
- `GAME_CTRL_HISCORE_EN` **not defined:** the port and register are absent. All other behaviour is identical.

## Structure
- **Shared package `trex_pkg`:**
  - State encodings `ST_IDLE`/`ST_RUN`/`ST_DEAD`.
  - Coordinate width constants: 11 for position, 10 for size.
  - BCD width 16.
- **Sub-module `bcd_counter4`:**
  - Ports: clk, async rst, `clr`, `inc`.
  - Behaviour: saturating at 9999.
  - Outputs: `value[15:0]` and `hund_roll`, a one-cycle pulse when the lower two digits wrap to 00.
- `game_ctrl` contains the FSM, the edge detect, the frame and hold counters, the collision compare, the speed register and the optional hi-score register.

## Test plan
- **Reset and start:** apply `rst` → all outputs at their reset values. Pulse `start` → `running` = 1 after 1 edge. After 6 more edges, `score_bcd` = 16'h0001.
- **Collision:**
  - Dino (50,100,40×43) with obstacle (89,120,20×30), `ObsValid` = 1 → DEAD after the next edge.
  - Obstacle moved to `ObsX` = 90 (touching edge) → no hit.
  - `ObsValid` = 0 → no hit.
- **Hit/tick tie:** collision on the same edge as the 6th frame tick → score unchanged, `isDead` = 1.
- **Restart lockout:**
  - `start` rise 10 frames after death → ignored.
  - Rise at frame 31 → RUN, score = 0, `speed` = 3.
- **Speed and saturation:**
  - Force score 0099 → the next tick gives 0100 and `speed` 3→4.
  - From 9999, 12 further ticks → score stays at 9999 and speed is unchanged.
  - Speed stops at 12.
- **Hi-score (macro on):**
  - Die at 0042 → `hiscore_bcd` = 0042.
  - Die at 0017 → stays at 0042.
  - Async `rst` → 0.
